bresenham_line_engine: RTL and testbench



---
 rtl/bresenham_line_engine_if.sv | 27 ++
 rtl/bresenham_line_engine.sv | 170 +++++++++++++++++
 tb/tb_bresenham_line_engine.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bresenham_line_engine_if.sv
// Endpoint request and pixel stream bundle between
// the line controller and the Bresenham engine.
interface bresenham_line_engine_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8
);
  logic           go;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output go, x0, y0, x1, y1,
    input  x, y, plot, busy, done
  );

  modport slave (
    input  go, x0, y0, x1, y1,
    output x, y, plot, busy, done
  );
endinterface

// File: rtl/bresenham_line_engine.sv
// Integer Bresenham rasteriser: one pixel per clock
// from (x0,y0) to (x1,y1) under a level go request.
module bresenham_line_engine #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int E_W = 11
) (
  input  logic csi_clockreset_clk,
  input  logic csi_clockreset_reset,
  bresenham_line_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRAW,
    DONE
  } state_t;

  state_t state;

  logic [X_W-1:0] x0_q;
  logic [Y_W-1:0] y0_q;
  logic [X_W-1:0] x1_q;
  logic [Y_W-1:0] y1_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  logic signed [E_W-1:0] dx;
  logic signed [E_W-1:0] dy;
  logic signed [E_W-1:0] err;
  logic                  sx_neg;
  logic                  sy_neg;

  logic plot_q;
  logic busy_q;
  logic done_q;

  logic signed [E_W-1:0] ax0;
  logic signed [E_W-1:0] ax1;
  logic signed [E_W-1:0] ay0;
  logic signed [E_W-1:0] ay1;
  logic signed [E_W-1:0] diff_x;
  logic signed [E_W-1:0] diff_y;
  logic signed [E_W-1:0] dx_init;
  logic signed [E_W-1:0] dy_init;

  logic signed [E_W:0]   e2;
  logic signed [E_W:0]   dx_ext;
  logic signed [E_W:0]   dy_ext;
  logic                  c1;
  logic                  c2;
  logic signed [E_W-1:0] err_step;
  logic                  at_end;

  // Zero-extend the latched endpoints into the signed error domain
  assign ax0 = $signed({{(E_W-X_W){1'b0}}, x0_q});
  assign ax1 = $signed({{(E_W-X_W){1'b0}}, x1_q});
  assign ay0 = $signed({{(E_W-Y_W){1'b0}}, y0_q});
  assign ay1 = $signed({{(E_W-Y_W){1'b0}}, y1_q});

  // Setup terms: dx is |x1-x0|, dy is -|y1-y0|
  always_comb begin
    diff_x  = ax1 - ax0;
    diff_y  = ay1 - ay0;
    dx_init = diff_x;
    dy_init = diff_y;
    if (diff_x < 0)
      dx_init = -diff_x;
    if (diff_y > 0)
      dy_init = -diff_y;
  end

  // Step decision; both tests use the same old error value
  always_comb begin
    e2       = $signed({err, 1'b0});
    dx_ext   = $signed({dx[E_W-1], dx});
    dy_ext   = $signed({dy[E_W-1], dy});
    c1       = (e2 >= dy_ext);
    c2       = (e2 <= dx_ext);
    err_step = err;
    if (c1)
      err_step = err_step + dy;
    if (c2)
      err_step = err_step + dx;
    at_end   = (x_q == x1_q) && (y_q == y1_q);
  end

  // Control FSM with registered pixel and status outputs
  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      state  <= IDLE;
      x0_q   <= '0;
      y0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.go) begin
            x0_q   <= bus.x0;
            y0_q   <= bus.y0;
            x1_q   <= bus.x1;
            y1_q   <= bus.y1;
            busy_q <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          x_q    <= x0_q;
          y_q    <= y0_q;
          dx     <= dx_init;
          dy     <= dy_init;
          err    <= dx_init + dy_init;
          sx_neg <= !(x0_q < x1_q);
          sy_neg <= !(y0_q < y1_q);
          plot_q <= 1'b1;
          state  <= DRAW;
        end
        DRAW: begin
          if (!bus.go) begin
            plot_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (at_end) begin
            plot_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            err <= err_step;
            if (c1)
              x_q <= sx_neg ? x_q - X_W'(1) : x_q + X_W'(1);
            if (c2)
              y_q <= sy_neg ? y_q - Y_W'(1) : y_q + Y_W'(1);
          end
        end
        DONE: begin
          if (!bus.go) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          plot_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.plot = plot_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Scoreboard bench: stimulus queues expected pixels,
// a monitor pops and compares each plotted pixel.
module tb_bresenham_line_engine;

  localparam int X_W = 9;
  localparam int Y_W = 8;

  logic clk;
  logic rst;

  bresenham_line_engine_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  bresenham_line_engine #(
    .X_W(X_W),
    .Y_W(Y_W),
    .E_W(11)
  ) dut (
    .csi_clockreset_clk  (clk),
    .csi_clockreset_reset(rst),
    .bus                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [X_W+Y_W-1:0] sb[$];

  int mon_cmp   = 0;
  int mon_bad   = 0;
  int mon_plots = 0;
  int st_cmp    = 0;
  int st_bad    = 0;

  // Monitor: every plotted pixel must match the queue head
  always @(posedge clk) begin
    #1;
    if (!rst && bus.plot) begin
      logic [X_W+Y_W-1:0] exp_p;
      mon_plots++;
      mon_cmp++;
      if (sb.size() == 0) begin
        mon_bad++;
        $display("FAIL pixel_extra got=(%0d,%0d) none expected",
                 bus.x, bus.y);
      end else begin
        exp_p = sb.pop_front();
        if ({bus.x, bus.y} !== exp_p) begin
          mon_bad++;
          $display("FAIL pixel got=(%0d,%0d) exp=(%0d,%0d)",
                   bus.x, bus.y, exp_p[X_W+Y_W-1:Y_W], exp_p[Y_W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp_v);
    st_cmp++;
    if (got !== exp_v) begin
      st_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp_v);
    end
  endtask

  task automatic push(input int px, input int py);
    sb.push_back({X_W'(px), Y_W'(py)});
  endtask

  // Reference rasteriser used only for the long line
  task automatic push_line(input int ax, input int ay,
                           input int bx, input int by);
    int ddx, ddy, stx, sty, e, e2;
    ddx = (bx > ax) ? bx - ax : ax - bx;
    ddy = (by > ay) ? ay - by : by - ay;
    stx = (ax < bx) ? 1 : -1;
    sty = (ay < by) ? 1 : -1;
    e = ddx + ddy;
    forever begin
      push(ax, ay);
      if (ax == bx && ay == by) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin
        e  += ddy;
        ax += stx;
      end
      if (e2 <= ddx) begin
        e  += ddx;
        ay += sty;
      end
    end
  endtask

  task automatic wait_drained(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(sb.size() == 0), 1);
  endtask

  // Full draw: latency, done timing, count, held go, release
  task automatic draw(input int ax, input int ay,
                      input int bx, input int by,
                      input int n_exp, input string nm);
    int start, k, prev, held_ok;
    @(negedge clk);
    bus.x0 = X_W'(ax);
    bus.y0 = Y_W'(ay);
    bus.x1 = X_W'(bx);
    bus.y1 = Y_W'(by);
    bus.go = 1'b1;
    start  = mon_plots;
    @(negedge clk);
    chk({nm, "_init_noplot"}, int'(bus.plot), 0);
    chk({nm, "_init_busy"}, int'(bus.busy), 1);
    @(negedge clk);
    chk({nm, "_first_plot"}, int'(bus.plot), 1);
    bus.x0 = 9'd77;
    bus.y0 = 8'd66;
    bus.x1 = 9'd55;
    bus.y1 = 8'd44;
    k = 0;
    prev = 0;
    while (!bus.done && k < 1000) begin
      prev = int'(bus.plot);
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, int'(bus.done), 1);
    chk({nm, "_done_after_plot"}, prev, 1);
    chk({nm, "_done_noplot"}, int'(bus.plot | bus.busy), 0);
    chk({nm, "_count"}, mon_plots - start, n_exp);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    held_ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (!bus.done || bus.busy || bus.plot) held_ok = 0;
    end
    chk({nm, "_done_held"}, held_ok, 1);
    bus.go = 1'b0;
    @(negedge clk);
    chk({nm, "_released"}, int'(bus.done | bus.busy | bus.plot), 0);
  endtask

  initial begin
    int ok;
    rst    = 1'b1;
    bus.go = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_flags", int'({bus.plot, bus.busy, bus.done}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-draw of a long horizontal line
    push(0, 0);
    push(1, 0);
    push(2, 0);
    bus.x0 = 9'd0;
    bus.y0 = 8'd0;
    bus.x1 = 9'd100;
    bus.y1 = 8'd0;
    bus.go = 1'b1;
    wait_drained("rstmid_plots");
    rst    = 1'b1;
    bus.go = 1'b0;
    #1;
    chk("rstmid_async", int'({bus.plot, bus.busy, bus.done}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", int'({bus.plot, bus.busy, bus.done}), 0);

    // Horizontal after reset
    push(0, 0);
    push(1, 0);
    push(2, 0);
    push(3, 0);
    draw(0, 0, 3, 0, 4, "horiz");

    // Single point
    push(5, 5);
    draw(5, 5, 5, 5, 1, "point");

    // Steep line
    push(0, 0);
    push(0, 1);
    push(1, 2);
    push(1, 3);
    push(2, 4);
    push(2, 5);
    draw(0, 0, 2, 5, 6, "steep");

    // Decreasing direction, full frame diagonal
    push_line(319, 239, 0, 0);
    chk("neg_model_len", sb.size(), 320);
    draw(319, 239, 0, 0, 320, "neg");

    // Abort by dropping go after three plots
    @(negedge clk);
    push(0, 0);
    push(1, 1);
    push(2, 2);
    bus.x0 = 9'd0;
    bus.y0 = 8'd0;
    bus.x1 = 9'd10;
    bus.y1 = 8'd10;
    bus.go = 1'b1;
    wait_drained("abort_plots");
    bus.go = 1'b0;
    @(negedge clk);
    chk("abort_stop", int'({bus.plot, bus.busy, bus.done}), 0);
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.plot || bus.busy) ok = 0;
    end
    chk("abort_no_done", ok, 1);

    // Short sloped line after abort, upward-left
    push(4, 0);
    push(3, 1);
    push(2, 1);
    push(1, 2);
    push(0, 2);
    draw(4, 0, 0, 2, 5, "slope");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             st_cmp + mon_cmp, st_bad + mon_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
